// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with circular return-address stack
module pc_unit #(
   parameter int PC_WIDTH = 15,
   parameter int OFF_WIDTH = 12,
   parameter int RAS_DEPTH = 4,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [2:0]                   op,
   input  logic [PC_WIDTH-1:0]          target,
   input  logic [OFF_WIDTH-1:0]         offset,
   output logic [PC_WIDTH-1:0]          pc_out,
   output logic [PC_WIDTH-1:0]          ras_top,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_full,
   output logic                         ras_empty,
   output logic                         ras_overflow,
   output logic                         ras_underflow
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [2:0] OP_SEQ  = 3'b000;
   localparam logic [2:0] OP_BR   = 3'b001;
   localparam logic [2:0] OP_JMP  = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;

   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] pc_br;
   logic [PC_WIDTH-1:0] stack [RAS_DEPTH];
   logic [PTR_W-1:0]    ptr;
   logic [CNT_W-1:0]    count;
   logic                ovf;
   logic                unf;
   logic                full;
   logic                empty;

   assign pc_inc = pc + PC_WIDTH'(1);
   assign pc_br  = pc + PC_WIDTH'($signed(offset));
   assign full   = (count == CNT_W'(RAS_DEPTH));
   assign empty  = (count == '0);

   // ptr always names the top entry; a push on a full stack wraps onto the oldest one
   always_ff @(posedge clk) begin
      if (reset) begin
         pc    <= RESET_VECTOR;
         ptr   <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else if (enable) begin
         case (op)
            OP_SEQ: pc <= pc_inc;
            OP_BR:  pc <= pc_br;
            OP_JMP: pc <= target;
            OP_CALL: begin
               stack[ptr + PTR_W'(1)] <= pc_inc;
               ptr <= ptr + PTR_W'(1);
               pc  <= target;
               if (full)
                  ovf <= 1'b1;
               else
                  count <= count + CNT_W'(1);
            end
            OP_RET: begin
               if (!empty) begin
                  pc    <= stack[ptr];
                  ptr   <= ptr - PTR_W'(1);
                  count <= count - CNT_W'(1);
               end else begin
                  pc  <= target;
                  unf <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign pc_out        = pc;
   assign ras_top       = empty ? '0 : stack[ptr];
   assign ras_count     = count;
   assign ras_full      = full;
   assign ras_empty     = empty;
   assign ras_overflow  = ovf;
   assign ras_underflow = unf;

endmodule
